// File: rtl/interp_pkg.sv
// Shared Q-format constants and divider state encoding for the interpolation datapath.
package interp_pkg;

  localparam int Q_WIDTH = 16;
  localparam int Q_FRAC  = 8;

  localparam logic [Q_WIDTH-1:0] Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/interp_fixed_divider.sv
// Sequential signed fixed-point divider: radix-2 restoring on magnitudes,
// then sign fix-up with saturation to the WIDTH-bit signed range.
module interp_fixed_divider
  import interp_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FRAC  = Q_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int NW = WIDTH + FRAC;
  localparam int CW = $clog2(NW + 1);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_X   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [NW-1:0]    POS_LIM = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [NW-1:0]    NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_INIT = CW'(NW);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [NW-1:0]    num_sr;
  logic [NW-1:0]    qmag;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   mag_b;
  logic             sign;

  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   abs_a;
  logic [WIDTH:0]   abs_b;
  logic [WIDTH+1:0] step_res;
  logic [WIDTH-1:0] fix_q;
  logic             fix_ovf;

  // One restoring step: shift next numerator bit into the remainder and
  // subtract the divisor only if it fits. Returns {new_remainder, quotient_bit}.
  function automatic logic [WIDTH+1:0] restore_step(input logic [WIDTH:0] r,
                                                    input logic           bit_in,
                                                    input logic [WIDTH:0] d);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    shifted = {r, bit_in};
    diff    = shifted - {1'b0, d};
    if (shifted >= {1'b0, d}) return {diff[WIDTH:0], 1'b1};
    else                      return {shifted[WIDTH:0], 1'b0};
  endfunction

  always_comb begin
    ext_a = {dvd_reg[WIDTH-1], dvd_reg};
    ext_b = {dvs_reg[WIDTH-1], dvs_reg};
    abs_a = ext_a[WIDTH] ? (~ext_a + ONE_X) : ext_a;
    abs_b = ext_b[WIDTH] ? (~ext_b + ONE_X) : ext_b;
  end

  always_comb begin
    step_res = restore_step(rem, num_sr[NW-1], mag_b);
  end

  always_comb begin
    fix_q   = qmag[WIDTH-1:0];
    fix_ovf = 1'b0;
    if (mag_b == '0) begin
      fix_q = dvd_reg[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else if (!sign) begin
      if (qmag > POS_LIM) begin
        fix_q   = SAT_MAX;
        fix_ovf = 1'b1;
      end
    end else if (qmag > NEG_LIM) begin
      fix_q   = SAT_MIN;
      fix_ovf = 1'b1;
    end else begin
      fix_q = ~qmag[WIDTH-1:0] + ONE_W;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= DIV_IDLE;
      count       <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      num_sr      <= '0;
      qmag        <= '0;
      rem         <= '0;
      mag_b       <= '0;
      sign        <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            dvd_reg     <= dividend;
            dvs_reg     <= divisor;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          // abs_a <= 2^(WIDTH-1), so its low WIDTH bits hold it exactly.
          num_sr <= {abs_a[WIDTH-1:0], {FRAC{1'b0}}};
          mag_b  <= abs_b;
          sign   <= dvd_reg[WIDTH-1] ^ dvs_reg[WIDTH-1];
          rem    <= '0;
          qmag   <= '0;
          count  <= CNT_INIT;
          state  <= (dvs_reg == '0) ? DIV_FIX : DIV_ITER;
        end
        DIV_ITER: begin
          rem    <= step_res[WIDTH+1:1];
          qmag   <= {qmag[NW-2:0], step_res[0]};
          num_sr <= {num_sr[NW-2:0], 1'b0};
          count  <= count - CNT_ONE;
          if (count == CNT_ONE) state <= DIV_FIX;
        end
        DIV_FIX: begin
          quotient    <= fix_q;
          overflow    <= fix_ovf;
          div_by_zero <= (mag_b == '0);
          state       <= DIV_DONE;
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign done = (state == DIV_DONE);
  assign busy = (state != DIV_IDLE);

endmodule

// File: tb/tb_interp_fixed_divider.sv
// Directed scoreboard bench for interp_fixed_divider: expected results from an
// integer reference model are queued at start and compared when done appears.
module tb_interp_fixed_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic        done;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] q;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  interp_fixed_divider #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .done(done),
    .busy(busy),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint n;
    longint d;
    longint qq;
    n = longint'($signed(a)) * 256;
    d = longint'($signed(b));
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = 27;
    if (d == 0) begin
      e.q   = a[15] ? 16'h8000 : 16'h7FFF;
      e.dbz = 1'b1;
      e.lat = 3;
    end else begin
      qq = n / d;
      if (qq > 32767) begin
        e.q = 16'h7FFF; e.ovf = 1'b1;
      end else if (qq < -32768) begin
        e.q = 16'h8000; e.ovf = 1'b1;
      end else begin
        e.q = qq[15:0];
      end
    end
    return e;
  endfunction

  // inject_at: cycle to pulse a stray start; rst_at: cycle to assert reset (0 = never).
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input int inject_at, input int rst_at, input string tag);
    exp_t e;
    int   c;
    bit   seen;
    bit   aborted;
    int   late_done;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0; dividend = ~a; divisor = b + 16'h0001;
    c = 1; seen = 0; aborted = 0;
    while (c <= 40 && !seen && !aborted) begin
      if (c == inject_at) begin
        start = 1'b1; dividend = 16'h1234; divisor = 16'h0010;
      end else begin
        start = 1'b0;
      end
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        check({tag, "_rst_q"}, 32'(quotient), 32'h0);
        check({tag, "_rst_flags"}, {28'h0, done, busy, div_by_zero, overflow}, 32'h0);
        e = sb.pop_front();
        late_done = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (done) late_done++;
        end
        check({tag, "_no_done_in_rst"}, 32'(late_done), 32'h0);
        rst = 1'b1;
        aborted = 1;
      end else begin
        check({tag, "_busy"}, 32'(busy), 32'h1);
        if (done) begin
          seen = 1;
          e = sb.pop_front();
          check({tag, "_q"}, 32'(quotient), 32'(e.q));
          check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
          check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
          check({tag, "_lat"}, 32'(c), 32'(e.lat));
        end else begin
          @(negedge clk);
          c++;
        end
      end
    end
    if (!aborted) begin
      if (!seen) begin
        check({tag, "_timeout"}, 32'h0, 32'h1);
        void'(sb.pop_front());
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_after"}, {30'h0, done, busy}, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("reset_q", 32'(quotient), 32'h0);
    check("reset_flags", {28'h0, done, busy, div_by_zero, overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_div(16'h0300, 16'h0180, 0, 0, "3_div_1p5");
    run_div(16'hFF00, 16'h0400, 0, 0, "m1_div_4");
    run_div(16'h0100, 16'h0300, 0, 0, "1_div_3");
    run_div(16'hFF00, 16'h0300, 0, 0, "m1_div_3");
    run_div(16'h0100, 16'h0000, 0, 0, "pos_div0");
    run_div(16'hFF00, 16'h0000, 0, 0, "neg_div0");
    run_div(16'h7F00, 16'h0001, 0, 0, "ovf_pos");
    run_div(16'h8000, 16'h0100, 0, 0, "min_exact");
    run_div(16'h8000, 16'hFF00, 0, 0, "min_neg");
    run_div(16'h0300, 16'h0180, 10, 0, "stray_start");
    run_div(16'h0A00, 16'h0100, 0, 12, "mid_reset");
    run_div(16'h0200, 16'h0100, 0, 0, "post_reset");
    for (int i = 0; i < 4; i++) begin
      run_div(16'($urandom), 16'($urandom_range(1, 16'hFFFF)), 0, 0, "random");
    end

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/interp_fixed_divider.md
# interp_fixed_divider

Sequential signed fixed-point divider serving the interpolation controller's divide request. The controller pulses `start` (its `start_div`) and waits in its divide-wait state until `done` (its `divider_done`) is seen. The quotient feeds the controller's loop-count/step registers. Implementation is radix-2 restoring on magnitudes, with sign fix-up and saturation.

## Interface
- `WIDTH`, 16: operand and quotient width, two's complement.
- `FRAC`, 8: fractional bits; all operands and the result are Q(WIDTH-FRAC).FRAC.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: divide request, sampled only in IDLE.
- `dividend` input WIDTH: numerator, captured on accepted `start`.
- `divisor` input WIDTH: denominator, captured on accepted `start`.
- `quotient` output WIDTH: result, valid from the `done` cycle, held until next accepted `start`.
- `done` output 1: one-cycle pulse, result valid.
- `busy` output 1: high from the cycle after acceptance through the `done` cycle.
- `div_by_zero` output 1: sticky with `quotient`; set when `divisor == 0`.
- `overflow` output 1: sticky with `quotient`; set when the result saturated.

## Operation
- Result = trunc_toward_zero((dividend << FRAC) / divisor), saturated to WIDTH-bit signed.
- States:
  - IDLE: `start`=1 captures operands, clears flags, goes to PREP.
  - PREP: forms |dividend|, |divisor| (WIDTH+1 bits, so -2^(WIDTH-1) is exact) and sign = msb(dividend) ^ msb(divisor). Divisor zero goes to FIX; otherwise goes to ITER with counter = WIDTH+FRAC.
  - ITER: one restoring step per cycle on {|dividend|, FRAC zeros}, shifting MSB first. Partial remainder is WIDTH+1 bits; quotient magnitude is WIDTH+FRAC bits. Decrement the counter; go to FIX when it reaches 1.
  - FIX:
    - Divide by zero: `quotient` = 0x7FFF-style max if dividend ≥ 0, else min (100…0); `div_by_zero`=1.
    - Otherwise, positive sign: magnitude > 2^(WIDTH-1)-1 gives max and `overflow`=1.
    - Otherwise, negative sign: magnitude > 2^(WIDTH-1) gives min and `overflow`=1.
    - Otherwise `quotient` = sign ? -mag : mag.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` while not in IDLE is ignored; no queueing.
- Operands are registered at acceptance, so input changes afterwards have no effect.
- Reset values: `quotient`=0, `done`=0, `busy`=0, `div_by_zero`=0, `overflow`=0, state IDLE.

## Timing
- Cycle 0 is the edge that samples `start`=1 in IDLE.
- Normal path: PREP at cycle 1, ITER cycles 2…WIDTH+FRAC+1, FIX at WIDTH+FRAC+2, `done` at WIDTH+FRAC+3. With defaults, `done` is at cycle 27.
- Zero-divisor path: PREP 1, FIX 2, `done` at cycle 3.
- `busy` is high for cycles 1…done cycle inclusive; it is low in the cycle after `done`.
- `start` held high across `done` is re-accepted on the first IDLE cycle (the cycle after `done`). The controller drops `start` after one cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous); no `done` is produced. The first `start` after reset deassertion is accepted normally.

## Structure
- The shared package `interp_pkg` holds:
  - the Q-format constants (`Q_WIDTH`=16, `Q_FRAC`=8), which are also used by the interpolation controller and multiplier;
  - `Q_MAX`/`Q_MIN` saturation constants;
  - the divider state enum.
- Single module, no sub-module. The restoring step is a local function (subtract, compare, shift).

## Test plan
- 0x0300 / 0x0180 (3.0/1.5) → `quotient`=0x0200, `done` pulse at cycle 27, flags 0, `busy` high cycles 1–27.
- 0xFF00 / 0x0400 (−1.0/4.0) → 0xFFC0. 0x0100 / 0x0300 → 0x0055. 0xFF00 / 0x0300 → 0xFFAB (truncation toward zero).
- 0x0100 / 0x0000 → 0x7FFF, `div_by_zero`=1, `done` at cycle 3. 0xFF00 / 0x0000 → 0x8000, `div_by_zero`=1.
- 0x7F00 / 0x0001 → 0x7FFF, `overflow`=1. 0x8000 / 0x0100 → 0x8000, `overflow`=0. 0x8000 / 0xFF00 → 0x7FFF, `overflow`=1.
- Second `start` pulse at cycle 10 with different operands → ignored; first result returned at cycle 27.
- `rst` low at cycle 12 of a divide → outputs 0 immediately, no `done`. A new divide 0x0200 / 0x0100 after release → 0x0200 with full latency.
